// File: rtl/eth_fcs_pkg.sv
// Shared types and helpers for the Ethernet FCS transmit path.
// CRC-32 constants plus bit-order reversal functions.
package eth_fcs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        FCS
    } state_e;

    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_fcs_tx_ctrl_if.sv
// Byte stream bundle around the FCS transmit sequencer.
// slave = sequencer view, master = producer/consumer view.
interface eth_fcs_tx_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_last;
    logic             s_ready;
    logic             fcs_bypass;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_last;
    logic             m_ready;
    logic             frame_done;
    logic [CNT_W-1:0] byte_cnt;

    modport slave (
        input  s_valid, s_data, s_last, fcs_bypass, m_ready,
        output s_ready, m_valid, m_data, m_last, frame_done, byte_cnt
    );

    modport master (
        output s_valid, s_data, s_last, fcs_bypass, m_ready,
        input  s_ready, m_valid, m_data, m_last, frame_done, byte_cnt
    );
endinterface

// File: rtl/crc32_byte_step.sv
// One-byte step of the IEEE 802.3 CRC-32 LFSR (MSB-first engine).
// Bytes arrive LSB-first on the wire, so they are reversed in.
module crc32_byte_step
    import eth_fcs_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [7:0]  d;
    logic [31:0] c;

    // Shift eight wire-order bits through the polynomial divider
    always_comb begin
        d = rev8(data_i);
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_o = c;
    end
endmodule

// File: rtl/eth_fcs_tx_ctrl.sv
// Transmit frame sequencer: forwards bytes, optionally pads, appends FCS.
// ETH_FCS_PAD_EN enables zero-padding of short frames to MIN_LEN.
module eth_fcs_tx_ctrl
    import eth_fcs_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int CNT_W   = 11
) (
    input logic              clk,
    input logic              rst_n,
    eth_fcs_tx_ctrl_if.slave bus
);
`ifdef ETH_FCS_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [31:0]      crc_q, crc_d, crc_in, crc_nxt, fcs;
    logic [CNT_W-1:0] len_q, len_d, len_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [1:0]       idx_q, idx_d;
    logic             byp_q, byp_d, byp_eff;
    logic             mv_q, mv_d, ml_q, ml_d;
    logic             done_q, done_d, run_q;
    logic [7:0]       md_q, md_d, step_byte;
    logic             ld, in_open, acc, xfer;

    assign ld        = !mv_q || bus.m_ready;
    assign in_open   = (state_q == IDLE) || (state_q == DATA);
    assign bus.s_ready = run_q && ld && in_open;
    assign acc       = bus.s_valid && bus.s_ready;
    assign xfer      = mv_q && bus.m_ready;
    assign crc_in    = (state_q == IDLE) ? CRC32_INIT : crc_q;
    assign step_byte = (state_q == PAD) ? 8'h00 : bus.s_data;
    assign fcs       = ~rev32(crc_q);
    assign byp_eff   = (state_q == IDLE) ? bus.fcs_bypass : byp_q;
    assign len_nxt   = (state_q == IDLE) ? CNT_W'(1) :
                       (len_q == CNT_MAX) ? len_q : len_q + 1'b1;

    crc32_byte_step u_crc (
        .crc_i  (crc_in),
        .data_i (step_byte),
        .crc_o  (crc_nxt)
    );

    // Sequencer: decide what the output register loads on each ld slot
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        byp_d   = byp_q;
        mv_d    = ld ? 1'b0 : mv_q;
        md_d    = md_q;
        ml_d    = ld ? 1'b0 : ml_q;
        case (state_q)
            IDLE, DATA: begin
                if (acc) begin
                    byp_d = byp_eff;
                    crc_d = crc_nxt;
                    len_d = len_nxt;
                    idx_d = 2'd0;
                    mv_d  = 1'b1;
                    md_d  = bus.s_data;
                    ml_d  = bus.s_last && byp_eff;
                    if (!bus.s_last) begin
                        state_d = DATA;
                    end else if (byp_eff) begin
                        state_d = IDLE;
                    end else if (PAD_EN && (len_nxt < MIN_C)) begin
                        state_d = PAD;
                    end else begin
                        state_d = FCS;
                    end
                end
            end
`ifdef ETH_FCS_PAD_EN
            PAD: begin
                if (ld) begin
                    crc_d = crc_nxt;
                    len_d = len_nxt;
                    mv_d  = 1'b1;
                    md_d  = 8'h00;
                    if (len_nxt >= MIN_C) begin
                        state_d = FCS;
                    end
                end
            end
`endif
            FCS: begin
                if (ld) begin
                    mv_d  = 1'b1;
                    md_d  = fcs[{idx_q, 3'b000} +: 8];
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        ml_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count bytes taken downstream; restart once frame_done has shown
    always_comb begin
        cnt_base = done_q ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (xfer && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
        done_d = xfer && ml_q;
    end

    // State, CRC and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            byp_q   <= 1'b0;
            mv_q    <= 1'b0;
            md_q    <= 8'h00;
            ml_q    <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byp_q   <= byp_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            ml_q    <= ml_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

    assign bus.m_valid    = mv_q;
    assign bus.m_data     = md_q;
    assign bus.m_last     = ml_q;
    assign bus.frame_done = done_q;
    assign bus.byte_cnt   = cnt_q;
endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Bench for eth_fcs_tx_ctrl: reference frame model plus per-cycle checker.
// Honours ETH_FCS_PAD_EN the same way the design does.
module tb_eth_fcs_tx_ctrl;
    localparam int CNT_W   = 11;
    localparam int MIN_LEN = 60;
`ifdef ETH_FCS_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    eth_fcs_tx_ctrl_if #(.CNT_W(CNT_W)) bus ();

    eth_fcs_tx_ctrl #(.MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic       exp_byp[$];
    logic [7:0] cur_frame[$];
    logic [7:0] last_frame[$];
    int  frames_seen = 0;
    int  stalls = 0;
    int  done_cnt = 0;
    int  last_len = 0;
    bit  toggle_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reflected (LSB-first) CRC-32, as in the usual software form
    function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    task automatic expect_frame(input logic [7:0] pl[$], input logic byp);
        logic [7:0]  f[$];
        logic [31:0] c;
        f = pl;
        if (!byp) begin
            if (PAD_ON) begin
                while (f.size() < MIN_LEN) f.push_back(8'h00);
            end
            c = 32'hFFFFFFFF;
            foreach (f[k]) c = crc_ref(c, f[k]);
            c = ~c;
            for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        end
        foreach (f[k]) begin
            exp_d.push_back(f[k]);
            exp_l.push_back(k == f.size() - 1);
        end
        exp_byp.push_back(byp);
    endtask

    task automatic send(input logic [7:0] pl[$], input logic byp);
        int   waitc;
        logic a;
        expect_frame(pl, byp);
        foreach (pl[i]) begin
            bus.s_valid    = 1'b1;
            bus.s_data     = pl[i];
            bus.s_last     = (i == pl.size() - 1);
            bus.fcs_bypass = byp;
            waitc = 0;
            forever begin
                @(negedge clk);
                a = bus.s_ready;
                @(posedge clk);
                #1;
                if (a) break;
                stalls++;
                waitc++;
                if (waitc > 100) begin
                    chk("accept_timeout", 32'(waitc), 0);
                    break;
                end
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_d.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_left", 32'(exp_d.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic        done_pend;
    logic        hold_chk;
    logic [7:0]  held_d;
    logic        held_l;
    logic [31:0] rc;
    logic        fb;

    // Per-cycle compare of the output stream against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            done_pend = 1'b0;
            hold_chk  = 1'b0;
            rc        = 32'hFFFFFFFF;
            cur_frame.delete();
        end else begin
            chk("frame_done", 32'(bus.frame_done), 32'(done_pend));
            if (bus.frame_done) begin
                chk("byte_cnt", 32'(bus.byte_cnt), 32'(last_len));
                done_cnt = 32'(bus.byte_cnt);
            end
            if (hold_chk) begin
                chk("hold_valid", 32'(bus.m_valid), 1);
                chk("hold_data", 32'(bus.m_data), 32'(held_d));
                chk("hold_last", 32'(bus.m_last), 32'(held_l));
            end
            hold_chk  = bus.m_valid && !bus.m_ready;
            held_d    = bus.m_data;
            held_l    = bus.m_last;
            done_pend = 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_byte", 32'(exp_d.size()), 1);
                end else begin
                    chk("m_data", 32'(bus.m_data), 32'(exp_d.pop_front()));
                    chk("m_last", 32'(bus.m_last), 32'(exp_l.pop_front()));
                end
                rc = crc_ref(rc, bus.m_data);
                cur_frame.push_back(bus.m_data);
                if (bus.m_last) begin
                    last_len   = cur_frame.size();
                    last_frame = cur_frame;
                    cur_frame.delete();
                    fb = 1'b1;
                    if (exp_byp.size() != 0) fb = exp_byp.pop_front();
                    if (!fb) chk("residue", bitrev(rc), 32'hC704DD7B);
                    rc = 32'hFFFFFFFF;
                    frames_seen++;
                    done_pend = 1'b1;
                end
            end
        end
    end

    // Downstream ready: steady or alternating
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = toggle_rdy ? ~bus.m_ready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s9[$];
        logic [7:0]  fa[$];
        logic [7:0]  fb2[$];
        logic [7:0]  z1[$];
        logic [7:0]  f60[$];
        logic [31:0] c;
        int          f0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h00;
        bus.s_last     = 1'b0;
        bus.fcs_bypass = 1'b0;
        s9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fa  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        fb2 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        z1  = '{8'h00};
        for (int i = 0; i < 60; i++) f60.push_back(8'(i + 1));

        c = 32'hFFFFFFFF;
        foreach (s9[k]) c = crc_ref(c, s9[k]);
        chk("model_crc_check", ~c, 32'hCBF43926);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_m_last", 32'(bus.m_last), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_byte_cnt", 32'(bus.byte_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(s9, 1'b0);
        wait_drain();
        chk("t1_len", 32'(last_frame.size()), 13);
        chk("t1_fcs", {last_frame[12], last_frame[11],
                       last_frame[10], last_frame[9]}, 32'hCBF43926);
        chk("t1_byte_cnt", 32'(done_cnt), 13);

        toggle_rdy = 1'b1;
        send(s9, 1'b0);
        wait_drain();
        toggle_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_len", 32'(last_frame.size()), 13);
        chk("t2_fcs", {last_frame[12], last_frame[11],
                       last_frame[10], last_frame[9]}, 32'hCBF43926);

        send(z1, 1'b0);
        wait_drain();
        chk("t3_len", 32'(last_frame.size()), PAD_ON ? 64 : 5);

        stalls = 0;
        f0 = frames_seen;
        send(fa, 1'b1);
        send(fb2, 1'b1);
        wait_drain();
        chk("t4_stalls", 32'(stalls), 0);
        chk("t4_frames", 32'(frames_seen - f0), 2);
        chk("t4_len", 32'(last_frame.size()), 5);
        chk("t4_tail", 32'(last_frame[4]), 32'hB4);

        send(s9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_fcs2_pre", 32'(bus.m_data), 32'hF4);
        rst_n = 1'b0;
        #1;
        chk("t5_m_valid", 32'(bus.m_valid), 0);
        chk("t5_m_data", 32'(bus.m_data), 0);
        chk("t5_m_last", 32'(bus.m_last), 0);
        chk("t5_s_ready", 32'(bus.s_ready), 0);
        chk("t5_byte_cnt", 32'(bus.byte_cnt), 0);
        exp_d.delete();
        exp_l.delete();
        exp_byp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(s9, 1'b0);
        wait_drain();
        chk("t5_fcs_after", {last_frame[12], last_frame[11],
                             last_frame[10], last_frame[9]}, 32'hCBF43926);

        send(f60, 1'b0);
        wait_drain();
        chk("t6_len", 32'(last_frame.size()), 64);
        chk("t6_last_payload", 32'(last_frame[59]), 32'h3C);
        chk("t6_byte_cnt", 32'(done_cnt), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eth_fcs_tx_ctrl.md
Name: eth_fcs_tx_ctrl

Overview:
Transmit-side frame sequencer for the Ethernet path. Accepts frame bytes on a valid/ready stream and forwards them through a single registered output stage. It drives a byte-wide CRC-32 (IEEE 802.3) update per accepted byte. After the last payload byte it optionally pads short frames, then appends the 4-byte FCS before the frame reaches the MAC serializer.

Parameters:
MIN_LEN, 60, minimum frame length in bytes excluding FCS; shorter frames are zero-padded (only with pad feature)
CNT_W, 11, width of frame byte counter (max 2047 bytes)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_last  in  1  marks final payload byte of frame
s_ready  out  1  input accepted when s_valid && s_ready
fcs_bypass  in  1  sampled with first byte of frame; 1 = forward frame unchanged, no pad, no FCS
m_valid  out  1  output byte valid
m_data  out  8  output byte
m_last  out  1  marks final byte of emitted frame
m_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse when m_last byte is accepted downstream
byte_cnt  out  CNT_W  bytes emitted in current frame (including pad/FCS), cleared after frame_done

Behaviour:
- Reset (rst_n=0, async): state IDLE; crc=32'hFFFFFFFF; m_valid=0, m_data=0, m_last=0, s_ready=0, frame_done=0, byte_cnt=0, bypass latch=0.
- Output stage: single register; loads when ld = !m_valid || m_ready; m_valid clears when m_ready && nothing loaded.
- s_ready = ld && state in {IDLE, DATA}; zero in PAD, FCS.
- Latency: accepted byte appears on m_data next cycle.
- CRC: byte bits reversed into engine (LSB-first wire order); init 32'hFFFFFFFF at each frame start; updated on every accepted payload byte and every generated pad byte; FCS = ~bitreverse32(crc), emitted least significant byte first.
- States:
  IDLE: on accept, latch fcs_bypass, CRC updates with byte, go DATA; if s_last also set, go to END decision directly.
  DATA: forward accepted bytes; on s_last: bypass -> m_last set on that byte, back IDLE; else if padding enabled and count+1 < MIN_LEN -> PAD; else FCS.
  PAD: emit 8'h00 each ld cycle, CRC updated; leave to FCS when count reaches MIN_LEN.
  FCS: emit 4 bytes, index 0..3, on each ld cycle; m_last on byte 3; after that, go IDLE.
- s_ready stays low until the last FCS byte has loaded; next frame may be accepted the cycle after.
- Back-to-back frames: no bubble required in bypass mode; CRC reinitialized at first byte regardless.
- m_ready low holds m_data/m_valid/m_last stable; no state advance.
- byte_cnt saturates at all-ones, no wrap; oversize frames still forwarded.
- Reset mid-frame: immediate return to reset values; partial frame discarded, no m_last emitted.

Optional Feature:
ETH_FCS_PAD_EN: defined -> short non-bypass frames zero-padded to MIN_LEN before FCS. Undefined -> PAD state absent, MIN_LEN ignored, FCS follows last payload byte directly.

Decomposition:
- Package eth_fcs_pkg: state enum (IDLE, DATA, PAD, FCS), CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hC704DD7B, byte-reverse and 32-bit reverse functions.
- Sub-module crc32_byte_step: purely combinational next-CRC from (crc, byte), poly 0x04C11DB7; controller owns the CRC register.

Test Plan:
- Pad off, bytes "123456789" (31..39 hex), m_ready=1 -> 13 output bytes, last four 26 39 F4 CB, m_last on CB, frame_done pulse, byte_cnt=13.
- Same frame with m_ready toggled 1/0 each cycle -> identical byte sequence, outputs stable while m_ready=0, no duplicates or drops.
- ETH_FCS_PAD_EN, 1-byte frame 8'h00 -> 60 bytes of 00 then 4 FCS bytes (64 total); running CRC over all 64 output bytes equals residue C704DD7B.
- fcs_bypass=1, 5-byte frame followed immediately by second 5-byte frame -> 10 bytes unchanged, m_last on bytes 5 and 10, no FCS, s_ready never low between frames.
- rst_n asserted during FCS byte 2 -> all outputs zero same cycle; after release, "123456789" frame yields correct FCS 26 39 F4 CB.
- Pad on, 60-byte frame -> no pad bytes, FCS follows immediately, 64 bytes total.
